i2s_rx: RTL and testbench
=========================

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 The block SHALL have these ports, with clock and reset first:
- clk  input  1  100 MHz system clock, the only clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable.
- sdout  input  1  serial data from the PmodI2S2 ADC (CS5343).
- mclk  output  1  ADC master clock.
- lrck  output  1  left/right word clock (0 = left, 1 = right).
- sclk  output  1  ADC serial bit clock.
- sample_l  output  16  last left sample, two's complement.
- sample_r  output  16  last right sample, two's complement.
- sample_mono  output  16  (L+R)/2, two's complement.
- valid  output  1  one-cycle strobe: new sample pair on the outputs.
- peak  output  16  maximum |sample_mono| since the last peak_clr.
- peak_clr  input  1  level-sensitive request to clear peak.

REQ-002 The block SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high; no other clock domain SHALL exist.

Function
REQ-003 A free-running 10-bit counter div SHALL increment by 1 every clk cycle and wrap from 1023 to 0.
REQ-004 The generated clocks SHALL be registered copies of counter bits, giving MCLK/LRCK = 256 and SCLK/LRCK = 64:
- mclk = div[1], 25 MHz.
- sclk = div[3], 6.25 MHz.
- lrck = div[9], about 97.66 kHz.
REQ-005 The bit slot SHALL be slot = div[8:4] (0..31), and the channel SHALL be ch = div[9].
REQ-006 sdout SHALL be sampled on the clk edge where div[3:0] = 4'hB, which is mid-SCLK-high.
REQ-007 Slot assignment SHALL follow I2S with a one-slot delay:
- Slot 1 is the MSB; slot 16 is the LSB.
- Slots 0 and 17..31 SHALL be ignored.
REQ-008 Bits SHALL be shifted MSB-first into a 16-bit shift register; the left word SHALL be latched into an internal hold register at the capture of slot 16 with ch = 0.
REQ-009 At the capture of slot 16 with ch = 1 (div = 779), the outputs SHALL update on the next edge, so they are visible when div = 780:
- sample_l <= left hold.
- sample_r <= completed right word.
- sample_mono <= arithmetic shift-right-by-1 of the 17-bit sign-extended sum L+R.
REQ-010 valid SHALL be high for exactly the one cycle when div = 780, i.e. once per 1024 cycles, coincident with the new output values.
REQ-011 sample_mono SHALL never overflow; for example, 16'h7FFF + 16'h7FFF gives 16'h7FFF, and 16'h8000 + 16'h8000 gives 16'h8000.
REQ-012 The peak meter SHALL work as follows:
- On each valid, peak <= max(peak, |sample_mono|).
- |16'h8000| SHALL saturate to 16'h7FFF.
REQ-013 peak_clr SHALL set peak to 0 on the next edge; if peak_clr and valid coincide, peak SHALL load |new sample_mono|, i.e. the clear SHALL win and the new sample SHALL then be applied.
REQ-014 en SHALL only gate the output update and the peak update:
- While en = 0, the clocks and div SHALL keep running.
- While en = 0, sample_l, sample_r, sample_mono and peak SHALL hold their values, and valid SHALL stay 0.
REQ-015 If en rises mid-frame, the first valid SHALL occur only after a complete frame; the frame starting at div = 0 after en = 1 is the earliest frame counted.
REQ-016 A pending-frame flag SHALL be set at div = 0 when en = 1, and cleared when en = 0; the output update SHALL require this flag.

Reset
REQ-017 While rst is high, and on the first edge after it deasserts, the following SHALL be 0:
- div and all generated clocks (mclk, lrck, sclk).
- sample_l, sample_r, sample_mono, peak and valid.
- The shift register, the hold register and the pending-frame flag.
REQ-018 A reset asserted mid-frame SHALL discard any partial word; no valid SHALL occur before a full frame completes after the release of rst.
REQ-019 After the release of rst, div = 0 on the first cycle, and the first possible valid SHALL be at div = 780 of the first full frame with en = 1.

Verification
REQ-020 The bench SHALL cover these scenarios, each stimulus leading to the stated response:
- Clock ratios: release rst and hold en = 1 -> mclk period 4 cycles, sclk period 16, lrck period 1024, all phase-aligned to div; valid every 1024 cycles at div = 780.
- Basic capture: the ADC model drives L = 16'h1234 and R = 16'hABCD (falling-sclk launch, one-slot delay) -> sample_l = 16'h1234, sample_r = 16'hABCD, sample_mono = 16'hDF00, peak = 16'h2100.
- Saturation and sign: L = R = 16'h8000 -> sample_mono = 16'h8000, peak = 16'h7FFF; then L = 16'h7FFF, R = 16'h0001 -> sample_mono = 16'h4000.
- Enable gating: set en = 0 at div = 300 -> no valid for that frame or later ones, outputs hold, clocks keep toggling; set en = 1 at div = 100 of a later frame -> first valid at div = 780 of the following frame.
- Peak clear collision: assert peak_clr in the same cycle as valid with |mono| = 16'h0010 while peak = 16'h5000 -> peak = 16'h0010 next cycle.
- Reset mid-frame: assert rst at div = 600 for 3 cycles -> all outputs 0 immediately; div restarts at 0; first valid 1804 cycles after the release of rst (780 + 1024); no corrupted word.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S receiver for a CS5343 ADC: divides clk into MCLK/SCLK/LRCK, deserialises L/R words and
// presents the pair (plus mono mix and peak meter) with a one-cycle valid at div = 780.
module i2s_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sdout,
  output logic        mclk,
  output logic        lrck,
  output logic        sclk,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r,
  output logic [15:0] sample_mono,
  output logic        valid,
  output logic [15:0] peak,
  input  logic        peak_clr
);

  logic [9:0]  div_q, div_d;
  logic        mclk_q, mclk_d, sclk_q, sclk_d, lrck_q, lrck_d;
  logic [15:0] shift_q, shift_d, hold_q, hold_d;
  logic        pend_q, pend_d;
  logic [15:0] l_q, l_d, r_q, r_d, mono_q, mono_d;
  logic        valid_q, valid_d;
  logic [15:0] peak_q, peak_d;

  logic [4:0]  slot;
  logic        ch, capture, word_done, update;
  logic [15:0] mono_new, mono_abs, peak_base;

  always_comb begin
    div_d  = div_q + 10'd1;
    // Clock outputs track the next divider value so they stay phase-aligned with div_q.
    mclk_d = div_d[1];
    sclk_d = div_d[3];
    lrck_d = div_d[9];

    slot      = div_q[8:4];
    ch        = div_q[9];
    capture   = (div_q[3:0] == 4'hB) && (slot != 5'd0) && (slot <= 5'd16);
    word_done = capture && (slot == 5'd16);
    update    = word_done && ch && pend_q && en;

    shift_d = capture ? {shift_q[14:0], sdout} : shift_q;
    hold_d  = (word_done && !ch) ? shift_d : hold_q;

    pend_d = pend_q;
    if (!en) begin
      pend_d = 1'b0;
    end else if (div_q == 10'd1023) begin
      pend_d = 1'b1;
    end

    // floor((L+R)/2) = (L>>>1) + (R>>>1) + (L[0] & R[0]); result always fits in 16 bits
    mono_new = {hold_q[15], hold_q[15:1]} + {shift_d[15], shift_d[15:1]}
             + {15'd0, hold_q[0] & shift_d[0]};

    l_d     = update ? hold_q   : l_q;
    r_d     = update ? shift_d  : r_q;
    mono_d  = update ? mono_new : mono_q;
    valid_d = update;

    if (mono_q == 16'h8000) begin
      mono_abs = 16'h7FFF;
    end else if (mono_q[15]) begin
      mono_abs = 16'd0 - mono_q;
    end else begin
      mono_abs = mono_q;
    end

    // Clear is applied first, so a clear coinciding with valid still records the new sample.
    peak_base = peak_clr ? 16'd0 : peak_q;
    peak_d    = peak_q;
    if (en) begin
      if (valid_q) begin
        peak_d = (mono_abs > peak_base) ? mono_abs : peak_base;
      end else if (peak_clr) begin
        peak_d = 16'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= 10'd0;
      mclk_q  <= 1'b0;
      sclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      shift_q <= 16'd0;
      hold_q  <= 16'd0;
      pend_q  <= 1'b0;
      l_q     <= 16'd0;
      r_q     <= 16'd0;
      mono_q  <= 16'd0;
      valid_q <= 1'b0;
      peak_q  <= 16'd0;
    end else begin
      div_q   <= div_d;
      mclk_q  <= mclk_d;
      sclk_q  <= sclk_d;
      lrck_q  <= lrck_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      l_q     <= l_d;
      r_q     <= r_d;
      mono_q  <= mono_d;
      valid_q <= valid_d;
      peak_q  <= peak_d;
    end
  end

  assign mclk        = mclk_q;
  assign sclk        = sclk_q;
  assign lrck        = lrck_q;
  assign sample_l    = l_q;
  assign sample_r    = r_q;
  assign sample_mono = mono_q;
  assign valid       = valid_q;
  assign peak        = peak_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: I2S ADC model on sdout, scoreboard of hand-computed sample pairs checked on valid.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sdout = 1'b0;
  logic        peak_clr = 1'b0;
  logic        mclk, lrck, sclk, valid;
  logic [15:0] sample_l, sample_r, sample_mono, peak;

  always #5 clk = ~clk;

  i2s_rx dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sdout(sdout),
    .mclk(mclk),
    .lrck(lrck),
    .sclk(sclk),
    .sample_l(sample_l),
    .sample_r(sample_r),
    .sample_mono(sample_mono),
    .valid(valid),
    .peak(peak),
    .peak_clr(peak_clr)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] mono;
    logic [15:0] pk;
  } exp_t;
  exp_t sb[$];

  // Reference frame position: edges since reset release, modulo the 1024-cycle frame.
  logic [9:0] tb_div;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_div <= 10'd0;
    else     tb_div <= tb_div + 10'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] l, input logic [15:0] r,
                          input logic [15:0] mono, input logic [15:0] pk);
    exp_t e;
    e.l = l; e.r = r; e.mono = mono; e.pk = pk;
    sb.push_back(e);
  endtask

  task automatic wait_div(input int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tb_div != d[9:0] && n < 2100);
    if (tb_div != d[9:0]) begin
      checks++;
      errors++;
      $display("FAIL wait_div timeout: actual=%0d required=%0d", tb_div, d);
    end
  endtask

  // ADC model: launches on falling SCLK, MSB one slot after each LRCK change.
  logic [15:0] adc_l = 16'h0;
  logic [15:0] adc_r = 16'h0;
  int          bitn = 0;
  logic        ps = 1'b0;
  logic        pl = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        bitn = 0; ps = 1'b0; pl = 1'b0; sdout = 1'b0;
      end else begin
        if (ps && !sclk) begin
          if (lrck != pl) bitn = 0;
          else            bitn++;
          pl = lrck;
        end
        ps = sclk;
        if (bitn >= 1 && bitn <= 16) sdout = lrck ? adc_r[16-bitn] : adc_l[16-bitn];
        else                         sdout = 1'b0;
      end
    end
  end

  // Monitor: every valid must match the oldest expected pair; peak is checked one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: actual=1 required=0 at div=%0d", tb_div);
        end else begin
          e = sb.pop_front();
          chk("valid_div", tb_div, 780);
          chk("sample_l", sample_l, e.l);
          chk("sample_r", sample_r, e.r);
          chk("sample_mono", sample_mono, e.mono);
          @(negedge clk);
          chk("peak", peak, e.pk);
          chk("valid_one_cycle", valid, 0);
        end
      end
    end
  end

  task automatic count_to_valid(input string name, input bit check_clocks);
    int first;
    int bad_m, bad_s, bad_l;
    first = -1; bad_m = 0; bad_s = 0; bad_l = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (mclk != tb_div[1]) bad_m++;
      if (sclk != tb_div[3]) bad_s++;
      if (lrck != tb_div[9]) bad_l++;
      if (valid) begin
        first = i;
        break;
      end
    end
    if (check_clocks) begin
      chk("mclk_eq_div1", bad_m, 0);
      chk("sclk_eq_div3", bad_s, 0);
      chk("lrck_eq_div9", bad_l, 0);
    end
    chk(name, first, 1804);
  endtask

  initial begin
    int tm, ts, tl;
    logic pm, pss, pll;

    en = 1'b1;
    adc_l = 16'h1234;
    adc_r = 16'hABCD;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {sample_l, sample_r, sample_mono, peak, valid, mclk, sclk, lrck}, 0);

    push_exp(16'h1234, 16'hABCD, 16'hDF00, 16'h2100);
    rst = 1'b0;
    count_to_valid("first_valid_cycles", 1'b1);

    wait_div(0);
    adc_l = 16'h8000; adc_r = 16'h8000;
    push_exp(16'h8000, 16'h8000, 16'h8000, 16'h7FFF);

    wait_div(0);
    adc_l = 16'h7FFF; adc_r = 16'h0001;
    push_exp(16'h7FFF, 16'h0001, 16'h4000, 16'h7FFF);

    wait_div(0);
    adc_l = 16'h5000; adc_r = 16'h5000;
    push_exp(16'h5000, 16'h5000, 16'h5000, 16'h5000);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;

    wait_div(0);
    adc_l = 16'hFFE0; adc_r = 16'h0000;
    push_exp(16'hFFE0, 16'h0000, 16'hFFF0, 16'h0010);
    wait_div(780);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;

    wait_div(0);
    adc_l = 16'h1111; adc_r = 16'h2222;
    push_exp(16'h1111, 16'h2222, 16'h1999, 16'h1999);

    wait_div(0);
    adc_l = 16'h7000; adc_r = 16'h7000;
    wait_div(300);
    en = 1'b0;

    wait_div(0);
    tm = 0; ts = 0; tl = 0;
    pm = mclk; pss = sclk; pll = lrck;
    repeat (1024) begin
      @(negedge clk);
      if (mclk != pm) tm++;
      if (sclk != pss) ts++;
      if (lrck != pll) tl++;
      pm = mclk; pss = sclk; pll = lrck;
    end
    chk("mclk_toggles_en0", tm, 512);
    chk("sclk_toggles_en0", ts, 128);
    chk("lrck_toggles_en0", tl, 2);
    chk("hold_outputs_en0", {sample_l, sample_r, sample_mono, peak},
        {16'h1111, 16'h2222, 16'h1999, 16'h1999});

    wait_div(100);
    en = 1'b1;
    wait_div(0);
    adc_l = 16'h4000; adc_r = 16'h2000;
    push_exp(16'h4000, 16'h2000, 16'h3000, 16'h3000);

    wait_div(0);
    adc_l = 16'h2468; adc_r = 16'h1357;
    wait_div(600);
    chk("all_expected_delivered", sb.size(), 0);
    rst = 1'b1;
    #1;
    chk("reset_midframe_outputs", {sample_l, sample_r, sample_mono, peak, valid, mclk, sclk, lrck}, 0);
    repeat (3) @(negedge clk);
    push_exp(16'h2468, 16'h1357, 16'h1BDF, 16'h1BDF);
    rst = 1'b0;
    count_to_valid("valid_after_reset_cycles", 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
